// File: rtl/contador_programa.sv
// Program counter of the single-cycle CPU: holds PC, the HALT state and the IN wait,
// and debounces the confirm button that releases an IN instruction.
module contador_programa #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
    parameter int unsigned           DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] proximo_pc,
    input  logic                  halt_instr,
    input  logic                  in_instr,
    input  logic                  confirma,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_addr,
    output logic                  parado,
    output logic                  aguardando_entrada,
    output logic                  escreve_in
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EXECUTA,
        ESPERA_IN,
        PARADO
    } estado_t;

    estado_t               estado;
    estado_t               proximo_estado;
    logic [DATA_WIDTH-1:0] pc_next;

    logic             s1;
    logic             s2;
    logic             estavel;
    logic             estavel_q;
    logic [CNT_W-1:0] cnt;
    logic             confirma_pulso;

    // Button path: the counter holds how many consecutive edges the synced level has
    // disagreed with the accepted level; the mismatch on the last allowed edge commits it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            estavel   <= 1'b0;
            estavel_q <= 1'b0;
            cnt       <= '0;
        end else begin
            s1        <= confirma;
            s2        <= s1;
            estavel_q <= estavel;
            if (s2 == estavel) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                estavel <= s2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign confirma_pulso = estavel & ~estavel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= EXECUTA;
            pc     <= RESET_PC;
        end else begin
            estado <= proximo_estado;
            pc     <= pc_next;
        end
    end

    always_comb begin
        proximo_estado = estado;
        pc_next        = pc;
        unique case (estado)
            EXECUTA: begin
                if (halt_instr) begin
                    proximo_estado = PARADO;
                end else if (in_instr) begin
                    proximo_estado = ESPERA_IN;
                end else begin
                    pc_next = proximo_pc;
                end
            end
            ESPERA_IN: begin
                if (confirma_pulso) begin
                    pc_next        = pc + DATA_WIDTH'(1);
                    proximo_estado = EXECUTA;
                end
            end
            default: begin
                proximo_estado = estado;
            end
        endcase
    end

    // Write enable is masked during reset so an aborted wait never commits a value.
    always_comb begin
        parado             = (estado == PARADO);
        aguardando_entrada = (estado == ESPERA_IN);
        escreve_in         = (estado == ESPERA_IN) && confirma_pulso && !reset;
    end

    assign pc_addr = pc[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_contador_programa.sv
// Randomized and directed bench for contador_programa against a behavioural model
// that tracks the button through a per-edge history of raw samples.
module tb_contador_programa;

    localparam int unsigned D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] proximo_pc;
    logic        halt_instr;
    logic        in_instr;
    logic        confirma;
    logic [31:0] pc;
    logic [9:0]  pc_addr;
    logic        parado;
    logic        aguardando_entrada;
    logic        escreve_in;

    contador_programa #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .RESET_PC       (32'h0),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proximo_pc        (proximo_pc),
        .halt_instr        (halt_instr),
        .in_instr          (in_instr),
        .confirma          (confirma),
        .pc                (pc),
        .pc_addr           (pc_addr),
        .parado            (parado),
        .aguardando_entrada(aguardando_entrada),
        .escreve_in        (escreve_in)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int esc_seen = 0;

    // Model state
    int          t = 0;
    int          last_reset = 0;
    int          last_clear = 0;
    bit          raw_at [0:16383];
    logic [31:0] pc_m = '0;
    bit          halted = 0;
    bit          waiting = 0;
    bit          est = 0;
    bit          est_prev = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, t);
        end
    endtask

    // Synchronized level seen by the debouncer just before edge j.
    function automatic bit s2_at(input int j);
        if (j - 2 > last_reset) return raw_at[j-2];
        return 1'b0;
    endfunction

    task automatic model_step();
        bit pulse;
        bit flip;
        t++;
        raw_at[t] = confirma;
        if (reset) begin
            pc_m = '0; halted = 0; waiting = 0;
            est = 0; est_prev = 0;
            last_clear = t; last_reset = t;
            return;
        end
        pulse = est && !est_prev;
        if (halted) begin
        end else if (waiting) begin
            if (pulse) begin
                pc_m = pc_m + 32'd1;
                waiting = 0;
            end
        end else if (halt_instr) begin
            halted = 1;
        end else if (in_instr) begin
            waiting = 1;
        end else begin
            pc_m = proximo_pc;
        end
        // Accepted level flips after D consecutive disagreeing edges since the last flip/reset.
        flip = (t - last_clear >= int'(D));
        for (int j = t - int'(D) + 1; j <= t; j++)
            if (flip && s2_at(j) == est) flip = 0;
        est_prev = est;
        if (flip) begin
            est = !est;
            last_clear = t;
        end
    endtask

    task automatic check_outputs();
        chk("pc", pc, pc_m);
        chk("pc_addr", pc_addr, pc_m[9:0]);
        chk("parado", parado, halted);
        chk("aguardando_entrada", aguardando_entrada, waiting);
        chk("escreve_in", escreve_in, waiting && est && !est_prev && !reset);
        if (escreve_in === 1'b1) esc_seen++;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int base;
    int hold_left;

    initial begin
        reset = 1'b1; proximo_pc = '0; halt_instr = 1'b0; in_instr = 1'b0; confirma = 1'b0;
        steps(2);
        chk("reset_pc", pc, 64'h0);
        chk("reset_parado", parado, 64'h0);
        reset = 1'b0;

        // Sequential fetch
        for (int v = 1; v <= 3; v++) begin
            proximo_pc = 32'(v);
            step();
            chk("fetch_pc", pc, 64'(v));
            chk("fetch_aguardando", aguardando_entrada, 64'h0);
        end

        // Halt holds PC against everything except reset
        proximo_pc = 32'd5; step();
        halt_instr = 1'b1; proximo_pc = 32'd9; step();
        chk("halt_parado", parado, 64'h1);
        for (int i = 0; i < 20; i++) begin
            proximo_pc = $urandom; confirma = 1'($urandom); in_instr = 1'($urandom);
            step();
        end
        chk("halt_pc_held", pc, 64'h5);
        reset = 1'b1; confirma = 1'b0; halt_instr = 1'b0; in_instr = 1'b0; step();
        chk("halt_reset_pc", pc, 64'h0);
        chk("halt_reset_parado", parado, 64'h0);
        reset = 1'b0; steps(D + 4);

        // Single confirmed press: exact latency
        proximo_pc = 32'd7; step();
        in_instr = 1'b1; step();
        in_instr = 1'b0; proximo_pc = 32'd100;
        confirma = 1'b1;
        for (int i = 1; i <= int'(D) + 3; i++) begin
            step();
            chk("latency_escreve", escreve_in, 64'(i == int'(D) + 2));
        end
        chk("latency_pc", pc, 64'h8);
        chk("latency_executa", aguardando_entrada, 64'h0);
        confirma = 1'b0; steps(D + 4);

        // Bounce gives exactly one write
        in_instr = 1'b1; step(); in_instr = 1'b0;
        base = esc_seen;
        for (int i = 0; i < 4; i++) begin confirma = 1'(~i[0]); step(); end
        confirma = 1'b1; steps(D + 6);
        chk("bounce_count", 64'(esc_seen - base), 64'h1);
        confirma = 1'b0; steps(D + 4);

        // Button already held on entry needs release and a new press
        confirma = 1'b1; steps(D + 4);
        in_instr = 1'b1; step(); in_instr = 1'b0;
        base = esc_seen;
        steps(8);
        chk("held_still_waiting", aguardando_entrada, 64'h1);
        confirma = 1'b0; steps(D + 4);
        chk("held_no_write", 64'(esc_seen - base), 64'h0);
        confirma = 1'b1; steps(D + 4);
        chk("held_new_press", 64'(esc_seen - base), 64'h1);
        chk("held_released", aguardando_entrada, 64'h0);
        confirma = 1'b0; steps(D + 4);

        // PC wrap on confirm
        proximo_pc = 32'hFFFF_FFFF; step();
        in_instr = 1'b1; step(); in_instr = 1'b0;
        confirma = 1'b1; steps(D + 3);
        chk("wrap_pc", pc, 64'h0);
        confirma = 1'b0; steps(D + 4);

        // HALT wins over IN, then reset mid-debounce aborts the wait
        halt_instr = 1'b1; in_instr = 1'b1; step();
        chk("halt_beats_in", parado, 64'h1);
        chk("halt_beats_in_wait", aguardando_entrada, 64'h0);
        halt_instr = 1'b0; in_instr = 1'b0; reset = 1'b1; step(); reset = 1'b0;
        proximo_pc = 32'd42; step();
        in_instr = 1'b1; step(); in_instr = 1'b0;
        base = esc_seen;
        confirma = 1'b1; steps(3);
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_pc", pc, 64'h0);
        chk("abort_state", aguardando_entrada, 64'h0);
        steps(D + 6);
        chk("abort_no_write", 64'(esc_seen - base), 64'h0);
        confirma = 1'b0; steps(D + 4);

        // Randomized traffic against the model
        hold_left = 0;
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            halt_instr = ($urandom_range(0, 39) == 0);
            in_instr   = ($urandom_range(0, 9) == 0);
            proximo_pc = $urandom;
            if (hold_left == 0) begin
                confirma  = 1'($urandom);
                hold_left = $urandom_range(1, 12);
            end
            hold_left--;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
